// File: rtl/pmem_arbiter.sv
// Two-client (icache/dcache) arbiter in front of a single-outstanding physical memory port.
// Round-robin on ties; pmem-side signals come only from registers latched at grant time.
module pmem_arbiter #(
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              icache_pmem_read,
    input  logic [31:0]       icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,

    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [31:0]       dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;

    localparam logic CLI_I = 1'b0;
    localparam logic CLI_D = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;

    logic              i_req;
    logic              d_req;
    logic              pick_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        i_req        = icache_pmem_read;
        d_req        = dcache_pmem_read | dcache_pmem_write;
        pick_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the client that did not win last time gets the grant.
                pick_d = d_req & (~i_req | (last_grant_q == CLI_I));
                if (pick_d) begin
                    state_d      = ST_GRANT_D;
                    last_grant_d = CLI_D;
                    addr_d       = dcache_pmem_address;
                    wdata_d      = dcache_pmem_wdata;
                    wr_d         = dcache_pmem_write;
                end else if (i_req) begin
                    state_d      = ST_GRANT_I;
                    last_grant_d = CLI_I;
                    addr_d       = icache_pmem_address;
                    wdata_d      = '0;
                    wr_d         = 1'b0;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                // Always return to IDLE so a dropped request is never regranted.
                if (pmem_resp) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= CLI_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
        end
    end

    logic busy;
    assign busy = (state_q != ST_IDLE);

    assign pmem_read    = busy & ~wr_q;
    assign pmem_write   = busy & wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign icache_pmem_resp  = (state_q == ST_GRANT_I) & pmem_resp;
    assign dcache_pmem_resp  = (state_q == ST_GRANT_D) & pmem_resp;
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

endmodule
